// File: rtl/calendar_ctrl.sv
// -----------------------------------------------------------------------------
// calendar_ctrl
//
// Day-resolution calendar holding a four-digit BCD year, a binary month and a
// binary day. A user load starts the calendar. After that, each tick advances
// the date by one day. Leap years follow the century rule. Year 0000 counts as
// leap. 9999-12-31 rolls over to 0000-01-01.
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 synchronous active-high reset
//   tick                advance the stored date by one day (RUN only)
//   load                load the ld_* date (accepted only if valid)
//   ld_Ym..ld_Yo [3:0]  BCD year digits to load (thousands..ones)
//   ld_month     [3:0]  binary month to load, 1..12
//   ld_day       [4:0]  binary day to load, 1..31
//   Ym..Yo       [3:0]  current BCD year, registered
//   month        [3:0]  current month, registered
//   day          [4:0]  current day, registered
//   LY                  current year is leap, registered with the year
//   valid               a user-loaded date is held (state RUN)
//   load_err            one-cycle pulse after a rejected load
//   year_wrap           one-cycle pulse after the 9999 -> 0000 rollover
// -----------------------------------------------------------------------------
module calendar_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_Ym,
    input  logic [3:0] ld_Yh,
    input  logic [3:0] ld_Yt,
    input  logic [3:0] ld_Yo,
    input  logic [3:0] ld_month,
    input  logic [4:0] ld_day,
    output logic [3:0] Ym,
    output logic [3:0] Yh,
    output logic [3:0] Yt,
    output logic [3:0] Yo,
    output logic [3:0] month,
    output logic [4:0] day,
    output logic       LY,
    output logic       valid,
    output logic       load_err,
    output logic       year_wrap
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;

    // Leap rule on BCD digits. lo is the last two digits and hi is the century.
    // A year ending in 00 is leap only when the century is a multiple of 4.
    function automatic logic leap_of(input logic [3:0] m, input logic [3:0] h,
                                     input logic [3:0] t, input logic [3:0] o);
        logic [6:0] lo;
        logic [6:0] hi;
        lo = {3'b000, t} * 7'd10 + {3'b000, o};
        hi = {3'b000, m} * 7'd10 + {3'b000, h};
        return ((lo[1:0] == 2'b00) && (lo != 7'd0)) ||
               ((lo == 7'd0) && (hi[1:0] == 2'b00));
    endfunction

    function automatic logic [4:0] month_len(input logic [3:0] mo, input logic lp);
        case (mo)
            4'd2:                    return lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                 return 5'd31;
        endcase
    endfunction

    // ---------------------------------------------------------------- load check
    logic ld_leap;
    logic ld_ok;

    assign ld_leap = leap_of(ld_Ym, ld_Yh, ld_Yt, ld_Yo);
    assign ld_ok   = (ld_Ym <= 4'd9) && (ld_Yh <= 4'd9) &&
                     (ld_Yt <= 4'd9) && (ld_Yo <= 4'd9) &&
                     (ld_month >= 4'd1) && (ld_month <= 4'd12) &&
                     (ld_day >= 5'd1) && (ld_day <= month_len(ld_month, ld_leap));

    // ------------------------------------------------------- BCD year increment
    logic       c_o, c_t, c_h, c_m;
    logic [3:0] yo_inc, yt_inc, yh_inc, ym_inc;

    assign c_o    = (Yo == 4'd9);
    assign c_t    = c_o && (Yt == 4'd9);
    assign c_h    = c_t && (Yh == 4'd9);
    assign c_m    = c_h && (Ym == 4'd9);
    assign yo_inc = c_o ? 4'd0 : Yo + 4'd1;
    assign yt_inc = c_o ? (c_t ? 4'd0 : Yt + 4'd1) : Yt;
    assign yh_inc = c_t ? (c_h ? 4'd0 : Yh + 4'd1) : Yh;
    assign ym_inc = c_h ? (c_m ? 4'd0 : Ym + 4'd1) : Ym;

    // ------------------------------------------------------ next-state / outputs
    logic [3:0] ym_d, yh_d, yt_d, yo_d, month_d;
    logic [4:0] day_d;
    logic       ly_d, load_err_d, year_wrap_d;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch.
        // Without the defaults, a path that skips an assignment infers a latch.
        state_d     = state_q;
        ym_d        = Ym;
        yh_d        = Yh;
        yt_d        = Yt;
        yo_d        = Yo;
        month_d     = month;
        day_d       = day;
        ly_d        = LY;
        load_err_d  = 1'b0;
        year_wrap_d = 1'b0;

        if (load) begin
            // Load takes priority: a tick in the same cycle is dropped even
            // when the load is rejected.
            if (ld_ok) begin
                state_d = RUN;
                ym_d    = ld_Ym;
                yh_d    = ld_Yh;
                yt_d    = ld_Yt;
                yo_d    = ld_Yo;
                month_d = ld_month;
                day_d   = ld_day;
                ly_d    = ld_leap;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick && (state_q == RUN)) begin
            if (day < month_len(month, LY)) begin
                day_d = day + 5'd1;
            end else if (month < 4'd12) begin
                day_d   = 5'd1;
                month_d = month + 4'd1;
            end else begin
                day_d       = 5'd1;
                month_d     = 4'd1;
                ym_d        = ym_inc;
                yh_d        = yh_inc;
                yt_d        = yt_inc;
                yo_d        = yo_inc;
                ly_d        = leap_of(ym_inc, yh_inc, yt_inc, yo_inc);
                year_wrap_d = c_m;
            end
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // register then samples pre-edge values, whatever the statement order.
        if (rst) begin
            state_q   <= IDLE;
            Ym        <= 4'd0;
            Yh        <= 4'd0;
            Yt        <= 4'd0;
            Yo        <= 4'd0;
            month     <= 4'd1;
            day       <= 5'd1;
            LY        <= 1'b1;
            load_err  <= 1'b0;
            year_wrap <= 1'b0;
        end else begin
            state_q   <= state_d;
            Ym        <= ym_d;
            Yh        <= yh_d;
            Yt        <= yt_d;
            Yo        <= yo_d;
            month     <= month_d;
            day       <= day_d;
            LY        <= ly_d;
            load_err  <= load_err_d;
            year_wrap <= year_wrap_d;
        end
    end

    assign valid = (state_q == RUN);

endmodule

// File: doc/calendar_ctrl.md
CALENDAR_CTRL -- requirements
Module: calendar_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-003 SHALL have port tick, input, 1, advance stored date by one day.
REQ-004 SHALL have port load, input, 1, request to load the ld_* date.
REQ-005 SHALL have ports ld_Ym, ld_Yh, ld_Yt, ld_Yo, input, 4 each, BCD year digits (thousands, hundreds, tens, ones) to load.
REQ-006 SHALL have port ld_month, input, 4, binary month 1-12.
REQ-007 SHALL have port ld_day, input, 5, binary day 1-31.
REQ-008 SHALL have ports Ym, Yh, Yt, Yo, output, 4 each, current BCD year, registered.
REQ-009 SHALL have port month, output, 4, current month, registered.
REQ-010 SHALL have port day, output, 5, current day, registered.
REQ-011 SHALL have port LY, output, 1, current year is leap, registered, coherent with the year outputs.
REQ-012 SHALL have port valid, output, 1, date is a user-loaded valid date.
REQ-013 SHALL have port load_err, output, 1, one-cycle pulse for a rejected load.
REQ-014 SHALL have port year_wrap, output, 1, one-cycle pulse on 9999 to 0000 rollover.

Function
REQ-015 SHALL implement FSM with states IDLE and RUN; reset enters IDLE.
REQ-016 SHALL, in IDLE, ignore tick.
REQ-017 SHALL leave IDLE for RUN on the first accepted load.
REQ-018 SHALL stay in RUN until rst; valid=1 exactly in RUN.
REQ-019 SHALL compute leap as follows:
- Let lo = 10*Yt+Yo and hi = 10*Ym+Yh.
- Leap = (lo mod 4 == 0 and lo != 0) or (lo == 0 and hi mod 4 == 0).
- Year 0000 is leap.
REQ-020 SHALL use month lengths 31,28/29,31,30,31,30,31,31,30,31,30,31; February length = 29 iff the leap rule holds.
REQ-021 SHALL accept a load only if all year digits <= 9, month in 1..12, and day in 1..length(month) using the leap status of the ld_* year.
REQ-022 SHALL, on an accepted load, update year, month, day and LY at the next edge and set load_err=0.
REQ-023 SHALL, on a rejected load, leave date, LY and state unchanged and assert load_err for exactly the next cycle.
REQ-024 SHALL, on tick in RUN with no load, update the outputs at the next edge (1-cycle latency):
- day < length: day+1.
- day == length and month < 12: day=1, month+1.
- day == 31, month == 12: day=1, month=1, year BCD+1 with per-digit carry; LY recomputed for the new year at the same edge.
REQ-025 SHALL, on 9999-12-31 plus tick, go to 0000-01-01 with LY=1 and pulse year_wrap for one cycle.
REQ-026 SHALL, when load and tick are asserted together, give load priority and discard tick, including when the load is rejected.
REQ-027 SHALL process back-to-back ticks, one day per cycle, with no dead cycles.
REQ-028 SHALL keep load_err and year_wrap low except during their defined pulse cycle.

Reset
REQ-029 SHALL, when rst=1 at an edge, set:
- Ym=Yh=Yt=Yo=0, month=1, day=1.
- LY=1, valid=0, load_err=0, year_wrap=0.
- State IDLE.
REQ-030 SHALL give rst priority over load and tick; rst mid-RUN discards the pending tick or load that cycle.

Verification
REQ-031 SHALL verify: load 2024-02-28, tick, tick -> 2024-02-29 then 2024-03-01, LY=1, valid=1.
REQ-032 SHALL verify: load 1900-02-29 -> load_err pulse, outputs unchanged; load 1900-02-28, tick -> 1900-03-01, LY=0.
REQ-033 SHALL verify: load 2000-02-28, tick -> 2000-02-29, LY=1; load 2100-02-28, tick -> 2100-03-01, LY=0.
REQ-034 SHALL verify: load 9999-12-31, tick -> 0000-01-01, year_wrap=1 for one cycle, LY=1; 1999-12-31, tick -> 2000-01-01.
REQ-035 SHALL verify: tick after reset -> no change, valid=0; load 2023-06-30 with tick same cycle -> 2023-06-30, not 07-01.
REQ-036 SHALL verify: load ld_Yo=0xA or ld_month=13 -> load_err=1, state stays IDLE; rst during tick stream -> 0000-01-01, valid=0 next cycle.
